// File: rtl/btn_tick_ctrl.sv
// Button front end for the rotating-LED shifter: sync, debounce, press detect,
// speed/direction/pause state and the shift-enable tick divider.
module btn_tick_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DB_W      = 20,
  parameter int unsigned TICK_BASE = 5000000,
  parameter int unsigned TICK_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_speed,
  input  logic       btn_dir,
  input  logic       btn_pause,
  output logic       tick,
  output logic       dir,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int unsigned B_SPD = 0;
  localparam int unsigned B_DIR = 1;
  localparam int unsigned B_PAU = 2;
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [TICK_W-1:0] P_BASE  = TICK_W'(TICK_BASE);

  logic [2:0]        w_btn_raw;
  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_db;
  logic [2:0]        r_db_q;
  logic [DB_W-1:0]   r_db_cnt [3];
  logic [2:0]        w_press;

  logic              r_tick;
  logic              r_dir;
  logic [1:0]        r_speed;
  logic              r_paused;
  logic [TICK_W-1:0] r_cnt;
  logic [TICK_W-1:0] w_period;
  logic [TICK_W-1:0] w_last;

  assign w_btn_raw = {btn_pause, btn_dir, btn_speed};

  // Any sample that agrees with the accepted level restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_db     <= '0;
      r_db_q   <= '0;
      r_db_cnt <= '{default: '0};
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press  = r_db & ~r_db_q;
  assign w_period = P_BASE >> r_speed;
  assign w_last   = w_period - 1'b1;

  // A speed press restarts the period at the new rate, even while paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick   <= 1'b0;
      r_dir    <= 1'b0;
      r_speed  <= '0;
      r_paused <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_tick <= 1'b0;
      if (w_press[B_SPD]) begin
        r_speed <= r_speed + 1'b1;
        r_cnt   <= '0;
      end else if (!r_paused) begin
        if (r_cnt == w_last) begin
          r_tick <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_press[B_DIR]) r_dir    <= ~r_dir;
      if (w_press[B_PAU]) r_paused <= ~r_paused;
    end
  end

  assign tick   = r_tick;
  assign dir    = r_dir;
  assign speed  = r_speed;
  assign paused = r_paused;

endmodule

// File: tb/tb_btn_tick_ctrl.sv
// Directed bench for btn_tick_ctrl with DB_CYCLES=4, TICK_BASE=16.
module tb_btn_tick_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_speed, btn_dir, btn_pause;
  logic       tick, dir, paused;
  logic [1:0] speed;

  int n_pass  = 0;
  int n_total = 0;

  btn_tick_ctrl #(
    .DB_CYCLES(4),
    .DB_W     (3),
    .TICK_BASE(16),
    .TICK_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_speed(btn_speed),
    .btn_dir  (btn_dir),
    .btn_pause(btn_pause),
    .tick     (tick),
    .dir      (dir),
    .speed    (speed),
    .paused   (paused)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  // Edges until tick is seen high; -1 if the bound expires.
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tick && n < max);
    if (!tick) n = -1;
  endtask

  initial begin
    int n;
    int ticks;
    int exp_p [4] = '{8, 4, 2, 16};

    rst = 1'b1; btn_speed = 1'b0; btn_dir = 1'b0; btn_pause = 1'b0;

    // 1: reset state and base tick rate
    step(3);
    chk("rst_tick", int'(tick), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_speed", int'(speed), 0);
    chk("rst_paused", int'(paused), 0);
    rst = 1'b0;
    wait_tick(40, n); chk("tick_first_16", n, 16);
    wait_tick(40, n); chk("tick_second_16", n, 16);
    wait_tick(40, n); chk("tick_third_16", n, 16);

    // 2: bouncing dir button, then a steady press
    for (int i = 0; i < 20; i++) begin
      btn_dir = ((i % 4) < 2);
      step(1);
    end
    chk("dir_bounce_rejected", int'(dir), 0);
    btn_dir = 1'b1;
    step(6); chk("dir_before_accept", int'(dir), 0);
    step(1); chk("dir_at_7", int'(dir), 1);
    btn_dir = 1'b0;
    step(12); chk("dir_release_noop", int'(dir), 1);

    // 3: speed presses 1,2,3,0
    for (int k = 0; k < 4; k++) begin
      btn_speed = 1'b1;
      step(6); chk("speed_before_accept", int'(speed), k);
      step(1); chk("speed_step", int'(speed), (k + 1) % 4);
      btn_speed = 1'b0;
      wait_tick(40, n); chk("first_tick_after_speed", n, exp_p[k]);
      wait_tick(40, n); chk("tick_period", n, exp_p[k]);
      step(8);
    end

    // 4: pause with cnt=5 at P=16, then resume
    wait_tick(40, n);
    step(14);
    btn_pause = 1'b1;
    step(7); chk("paused_set", int'(paused), 1);
    btn_pause = 1'b0;
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (tick) ticks++;
    end
    chk("no_tick_while_paused", ticks, 0);
    btn_pause = 1'b1;
    step(7); chk("paused_clear", int'(paused), 0);
    btn_pause = 1'b0;
    wait_tick(40, n); chk("resume_first_tick", n, 11);
    wait_tick(40, n); chk("resume_period", n, 16);

    // 5: speed and dir pressed together
    btn_speed = 1'b1; btn_dir = 1'b1;
    step(6);
    chk("combo_speed_before", int'(speed), 0);
    chk("combo_dir_before", int'(dir), 1);
    step(1);
    chk("combo_speed", int'(speed), 1);
    chk("combo_dir", int'(dir), 0);
    btn_speed = 1'b0; btn_dir = 1'b0;
    step(10);

    // 6: reset while paused and mid-debounce, button held through it
    btn_pause = 1'b1;
    step(7); chk("pre_rst_paused", int'(paused), 1);
    btn_pause = 1'b0;
    step(10);
    btn_speed = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    chk("rst2_paused", int'(paused), 0);
    chk("rst2_speed", int'(speed), 0);
    chk("rst2_dir", int'(dir), 0);
    chk("rst2_tick", int'(tick), 0);
    rst = 1'b0;
    step(6); chk("held_before_accept", int'(speed), 0);
    step(1); chk("held_accepted", int'(speed), 1);
    wait_tick(40, n); chk("held_first_tick", n, 8);
    step(20); chk("held_single_press", int'(speed), 1);
    btn_speed = 1'b0;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
